// File: rtl/seg_scan_arbiter.sv
// Two-requester arbiter driving an 8-digit multiplexed 7-segment display.
// Ownership and the shown value change only at scan-frame boundaries.
module seg_scan_arbiter #(
   parameter int PRESCALE = 16384,
   parameter int HOLD     = 4
) (
   input  logic        CLK,
   input  logic        CPU_RESETN,
   input  logic        REQ_A,
   input  logic [15:0] VAL_A,
   input  logic        REQ_B,
   input  logic [15:0] VAL_B,
   output logic        GNT_A,
   output logic        GNT_B,
   output logic [6:0]  C,
   output logic [7:0]  AN
);

   localparam int CW = $clog2(PRESCALE);
   localparam int HW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_TAG_A = 7'b0001000;
   localparam logic [6:0] GLYPH_TAG_B = 7'b0000011;

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   val_q, val_d;
   logic          gnt_a_q, gnt_b_q;
   logic [6:0]    c_q, c_d;
   logic [7:0]    an_q, an_d;
   logic          tick, boundary, hold_full;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   // Arbitration and value latching; everything here is frozen between boundaries.
   always_comb begin
      // NOTE: every next-state signal gets a default before any branch so no latch is inferred.
      tick      = (cnt_q == CNT_MAX);
      boundary  = tick && (idx_q == 3'd7);
      hold_full = (hold_q >= HOLD_LAST);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      idx_d     = tick ? idx_q + 3'd1 : idx_q;
      state_d   = state_q;
      hold_d    = hold_q;
      val_d     = val_q;

      if (boundary) begin
         case (state_q)
            IDLE: begin
               if (REQ_B)      state_d = OWN_B;
               else if (REQ_A) state_d = OWN_A;
            end
            OWN_A: begin
               if (!REQ_A)                  state_d = REQ_B ? OWN_B : IDLE;
               else if (REQ_B && hold_full) state_d = OWN_B;
            end
            OWN_B: begin
               if (!REQ_B)                  state_d = REQ_A ? OWN_A : IDLE;
               else if (REQ_A && hold_full) state_d = OWN_A;
            end
            default: state_d = IDLE;
         endcase

         // hold_q counts frames completed by the current owner, including the one ending now.
         if (state_d != state_q)
            hold_d = '0;
         else if (state_q != IDLE && hold_q != HOLD_MAX)
            hold_d = hold_q + 1'b1;

         if (state_d == OWN_A)      val_d = VAL_A;
         else if (state_d == OWN_B) val_d = VAL_B;
      end
   end

   // Glyph for the slot that becomes active on this tick, using next-frame owner/value.
   always_comb begin
      an_d = an_q;
      c_d  = c_q;
      if (tick) begin
         if (state_d == IDLE) begin
            an_d = 8'hFF;
            c_d  = GLYPH_BLANK;
         end else begin
            an_d = ~(8'b1 << idx_d);
            case (idx_d)
               3'd0:    c_d = hex_glyph(val_d[3:0]);
               3'd1:    c_d = hex_glyph(val_d[7:4]);
               3'd2:    c_d = hex_glyph(val_d[11:8]);
               3'd3:    c_d = hex_glyph(val_d[15:12]);
               3'd7:    c_d = (state_d == OWN_A) ? GLYPH_TAG_A : GLYPH_TAG_B;
               default: c_d = GLYPH_BLANK;
            endcase
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge CLK) begin
      // NOTE: the value register is reset too, so the first owned frame never shows stale data.
      if (!CPU_RESETN) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= IDLE;
         hold_q  <= '0;
         val_q   <= '0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         c_q     <= GLYPH_BLANK;
         an_q    <= 8'hFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         val_q   <= val_d;
         gnt_a_q <= (state_d == OWN_A);
         gnt_b_q <= (state_d == OWN_B);
         c_q     <= c_d;
         an_q    <= an_d;
      end
   end

   assign GNT_A = gnt_a_q;
   assign GNT_B = gnt_b_q;
   assign C     = c_q;
   assign AN    = an_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter at PRESCALE=4, HOLD=2 (frame = 32 cycles).
// Cycle numbers below count rising edges since the last reset release.
module tb_seg_scan_arbiter;

   localparam int PRESCALE = 4;
   localparam int HOLD     = 2;

   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_TAG_A = 7'b0001000;
   localparam logic [6:0] G_TAG_B = 7'b0000011;

   logic        CLK = 1'b0;
   logic        CPU_RESETN;
   logic        REQ_A, REQ_B;
   logic [15:0] VAL_A, VAL_B;
   logic        GNT_A, GNT_B;
   logic [6:0]  C;
   logic [7:0]  AN;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   logic [6:0] exp_c  [8] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001,
                              G_BLANK, G_BLANK, G_BLANK, G_TAG_A};

   seg_scan_arbiter #(.PRESCALE(PRESCALE), .HOLD(HOLD)) dut (
      .CLK        (CLK),
      .CPU_RESETN (CPU_RESETN),
      .REQ_A      (REQ_A),
      .VAL_A      (VAL_A),
      .REQ_B      (REQ_B),
      .VAL_B      (VAL_B),
      .GNT_A      (GNT_A),
      .GNT_B      (GNT_B),
      .C          (C),
      .AN         (AN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_gnt(input string tag, input logic a, input logic b);
      check({tag, ".gnt_a"}, 16'(GNT_A), 16'(a));
      check({tag, ".gnt_b"}, 16'(GNT_B), 16'(b));
   endtask

   task automatic check_disp(input string tag, input logic [7:0] an, input logic [6:0] c);
      check({tag, ".an"}, 16'(AN), 16'(an));
      check({tag, ".c"},  16'(C),  16'(c));
   endtask

   initial begin
      CPU_RESETN = 1'b0;
      REQ_A = 1'b0; REQ_B = 1'b0;
      VAL_A = 16'h0000; VAL_B = 16'h0000;
      cycles(2);
      check_gnt("reset", 1'b0, 1'b0);
      check_disp("reset", 8'hFF, G_BLANK);

      // Nobody requests for three frames: display stays dark.
      CPU_RESETN = 1'b1;
      for (int i = 1; i <= 96; i++) begin
         cycles(1);
         check_gnt("idle", 1'b0, 1'b0);
         check_disp("idle", 8'hFF, G_BLANK);
      end

      // A requests before the first boundary; grant at cycle 32.
      CPU_RESETN = 1'b0;
      cycles(1);
      CPU_RESETN = 1'b1;
      REQ_A = 1'b1; VAL_A = 16'h12AF;
      cycles(31);
      check_gnt("a_pre", 1'b0, 1'b0);
      cycles(1);
      check_gnt("a_grant", 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cycles(1);
         check_disp($sformatf("a_slot%0d_start", k), exp_an[k], exp_c[k]);
         // A withdraws and changes its value mid-frame; the frame must finish unchanged.
         if (k == 0) begin
            REQ_A = 1'b0;
            VAL_A = 16'h3456;
         end
         cycles(3);
         check_disp($sformatf("a_slot%0d_end", k), exp_an[k], exp_c[k]);
         check_gnt($sformatf("a_slot%0d_frozen", k), 1'b1, 1'b0);
      end
      cycles(1);
      check_gnt("a_release", 1'b0, 1'b0);
      check_disp("a_release", 8'hFF, G_BLANK);

      // Both request from IDLE: B first, then alternate every two frames.
      for (int c = 65; c <= 245; c++) begin
         logic ea, eb;
         cycles(1);
         if (c == 70) begin
            REQ_A = 1'b1; VAL_A = 16'h0C0D;
            REQ_B = 1'b1; VAL_B = 16'hBEEF;
         end
         eb = (c >= 96 && c < 160) || (c >= 224);
         ea = (c >= 160 && c < 224);
         check_gnt($sformatf("rr_c%0d", c), ea, eb);
         case (c)
            96:  check_disp("rr_b_d0", 8'hFE, 7'b0001110);
            100: check_disp("rr_b_d1", 8'hFD, 7'b0000110);
            124: check_disp("rr_b_d7", 8'h7F, G_TAG_B);
            160: check_disp("rr_a_d0", 8'hFE, 7'b0100001);
            164: check_disp("rr_a_d1", 8'hFD, 7'b1000000);
            188: check_disp("rr_a_d7", 8'h7F, G_TAG_A);
            224: check_disp("rr_b2_d0", 8'hFE, 7'b0001110);
            default: ;
         endcase
      end

      // One-cycle reset pulse while B owns and digit 5 is active.
      CPU_RESETN = 1'b0;
      cycles(1);
      check_gnt("rst_pulse", 1'b0, 1'b0);
      check_disp("rst_pulse", 8'hFF, G_BLANK);
      check("rst_pulse.idx", 16'(dut.idx_q), 16'h0000);
      CPU_RESETN = 1'b1;
      cycles(31);
      check_gnt("regrant_pre", 1'b0, 1'b0);
      cycles(1);
      check_gnt("regrant", 1'b0, 1'b1);
      check_disp("regrant", 8'hFE, 7'b0001110);

      // B withdraws in its first frame with A waiting: A takes over despite hold < HOLD.
      REQ_B = 1'b0;
      VAL_A = 16'h5678;
      cycles(31);
      check_gnt("handover_pre", 1'b0, 1'b1);
      cycles(1);
      check_gnt("handover", 1'b1, 1'b0);
      check_disp("handover", 8'hFE, 7'b0000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg_scan_arbiter.md
SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 Parameter PRESCALE, default 16384, CLK cycles per digit slot (legal range 2 or more).
REQ-002 Parameter HOLD, default 4, minimum number of full scan frames a grant is held (legal range 1 or more).
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 CPU_RESETN  input  1  synchronous, active-low reset.
REQ-005 REQ_A  input  1  requester A (operand entry) wants the display.
REQ-006 VAL_A  input  16  requester A value, four hex digits.
REQ-007 REQ_B  input  1  requester B (result) wants the display.
REQ-008 VAL_B  input  16  requester B value, four hex digits.
REQ-009 GNT_A  output  1  registered; A owns the display.
REQ-010 GNT_B  output  1  registered; B owns the display.
REQ-011 C  output  7  registered active-low segments, bit order g..a (bit 6 = g).
REQ-012 AN  output  8  registered active-low anodes, bit n = digit n.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and wraps; tick = (count == PRESCALE-1).
REQ-014 Digit index 0..7 advances by 1 on each tick and wraps 7->0; frame boundary = tick while index == 7.
REQ-015 FSM states: IDLE, OWN_A, OWN_B; GNT_A = (state == OWN_A), GNT_B = (state == OWN_B), never both 1.
REQ-016 FSM evaluates only at frame boundaries; between boundaries state, GNT and latched value are frozen regardless of REQ changes.
REQ-017 IDLE at boundary: REQ_B -> OWN_B; else REQ_A -> OWN_A; else stay IDLE (B has priority on a tie).
REQ-018 Hold counter clears on entry to OWN_A or OWN_B and increments per completed frame, saturating at HOLD.
REQ-019 OWN_x at boundary with owner request low -> the other requester's state if it is requesting, else IDLE; this applies regardless of the hold counter.
REQ-020 OWN_x at boundary with owner request high, other requesting, and hold == HOLD -> other state (round robin).
REQ-021 OWN_x at boundary with owner request high, and either the other is idle or hold < HOLD -> stay.
REQ-022 Display value register loads VAL of the next-frame owner at each frame boundary, so one frame shows one consistent value.
REQ-023 Value register does not track VAL changes mid-frame.
REQ-024 On the cycle after each tick, AN drives only bit (new index) low and C drives that slot's glyph.
REQ-025 Digits 0-3 show hex nibbles [3:0], [7:4], [11:8], [15:12] of the display value.
REQ-026 Digits 4-6 are blank (C = 1111111).
REQ-027 Digit 7 shows the owner tag: A = 0001000, b = 0000011.
REQ-028 In IDLE, AN = 11111111 and C = 1111111 for the whole frame; scanning counters keep running.
REQ-029 Hex glyphs (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-030 AN/C update latency is exactly 1 CLK after the tick; AN/C are stable between ticks.

Reset
REQ-031 CPU_RESETN low at a rising edge sets prescaler = 0, index = 0, state = IDLE, hold = 0, and display value = 0.
REQ-032 CPU_RESETN low at a rising edge sets GNT_A = 0, GNT_B = 0, AN = 11111111 and C = 1111111.
REQ-033 Reset asserted mid-frame or mid-grant takes effect at that edge with no partial-frame completion.
REQ-034 After release, the first frame boundary occurs 8*PRESCALE cycles later.

Verification (PRESCALE=4, HOLD=2)
REQ-035 Both idle for 3 frames -> GNT_A = GNT_B = 0, AN = FF, C = 7F throughout, and tick every 4 cycles.
REQ-036 REQ_A = 1, VAL_A = 16'h12AF before the first boundary -> GNT_A rises at the boundary (cycle 32 after reset).
REQ-036a Same stimulus as REQ-036 -> in the next frame AN = FE,FD,FB,F7,EF,DF,BF,7F in turn, with C = 0001110, 0001000, 0100100, 1111001, blank, blank, blank, 0001000.
REQ-037 REQ_A and REQ_B both high from IDLE -> GNT_B is granted first.
REQ-037a Both held high -> the grant alternates B, A, B every 2 frames, and the GNT outputs change only at frame boundaries.
REQ-038 A owns, REQ_A drops mid-frame, VAL_A changes mid-frame -> the frame completes showing the old value.
REQ-038a Same stimulus as REQ-038 -> at the boundary the FSM goes to IDLE, or to OWN_B if REQ_B = 1, even with hold < HOLD.
REQ-039 CPU_RESETN pulsed low for 1 cycle during an OWN_B frame at index 5 -> the next cycle shows GNT_B = 0, AN = FF, C = 7F and index = 0.
REQ-039a Same stimulus as REQ-039 -> the regrant occurs at cycle 32 after release.
